// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one aligned word access per LOAD/STORE with byte enables and load extension.
// Latency: 3 cycles best case (request, bus ack, done); +1 per wait cycle, abort after TIMEOUT cycles.
// Backpressure: stall holds the core while the access is outstanding; bus_req is held until bus_ack.
module lsu_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_vld,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             fail_q;
    logic             ld_ok_q;

    logic             legal_f3;
    logic             misalign;
    logic [3:0]       be_nxt;
    logic [31:0]      wdata_nxt;
    logic [31:0]      shifted;
    logic [31:0]      ext;

    always_comb begin
        legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << addr[1:0];
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata;
            end
        endcase
    end

    // The addressed byte/half is moved down to lane 0 before extension.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            fail_q    <= 1'b0;
            ld_ok_q   <= 1'b0;
            ld_data   <= 32'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        bus_we    <= mem_rw;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_nxt;
                        bus_wdata <= wdata_nxt;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        cnt       <= '0;
                        ld_ok_q   <= 1'b0;
                        if (!legal_f3 || misalign) begin
                            fail_q <= 1'b1;
                            state  <= DONE;
                            if (!mem_rw) ld_data <= 32'd0;
                        end else begin
                            fail_q <= 1'b0;
                            state  <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the final allowed cycle still completes the access.
                    if (bus_ack) begin
                        state <= DONE;
                        if (!bus_we) begin
                            ld_data <= ext;
                            ld_ok_q <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state  <= DONE;
                        fail_q <= 1'b1;
                        if (!bus_we) ld_data <= 32'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset also forces stall low so the core is released immediately.
    assign stall   = rst_n & mem_req & (state != DONE);
    assign bus_req = (state == ACCESS);
    assign ld_vld  = (state == DONE) & ld_ok_q;
    assign err     = (state == DONE) & fail_q;
endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_rw;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_vld;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    lsu_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_rw(mem_rw), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .ld_vld(ld_vld),
        .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at negedge+1; drives one access and follows it to DONE, then one more cycle.
    task automatic run_op(input string name, input logic rw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                          input int waits, input bit never_ack,
                          input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                          input logic [31:0] exp_bwd, input logic exp_vld, input logic exp_err,
                          input logic [31:0] exp_ld, input int exp_stall, input int exp_breq);
        int  stall_cyc = 0;
        int  breq_cyc  = 0;
        bit  done      = 1'b0;
        exp_t e;
        sb.push_back('{vld: exp_vld, err: exp_err, data: exp_ld});
        mem_req = 1'b1; mem_rw = rw; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        #1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (stall) stall_cyc++;
            if (bus_req) begin
                breq_cyc++;
                if (breq_cyc == 1) begin
                    check({name, "_bus_addr"}, bus_addr, exp_baddr);
                    check({name, "_bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
                    check({name, "_bus_we"}, {31'd0, bus_we}, {31'd0, rw});
                    if (rw) check({name, "_bus_wdata"}, bus_wdata, exp_bwd);
                end
                bus_ack   = !never_ack && (breq_cyc == waits + 1);
                bus_rdata = bus_ack ? rdata : 32'h5A5A_5A5A;
            end else begin
                bus_ack = 1'b0;
            end
            if (mem_req && !stall) begin
                done = 1'b1;
                e = sb.pop_front();
                check({name, "_ld_vld"}, {31'd0, ld_vld}, {31'd0, e.vld});
                check({name, "_err"}, {31'd0, err}, {31'd0, e.err});
                check({name, "_ld_data"}, ld_data, e.data);
                mem_req = 1'b0;
            end
            @(negedge clk); #1;
        end
        if (!done) begin
            errors++;
            $error("FAIL %s_no_done: observed no completion expected completion", name);
            void'(sb.pop_front());
            mem_req = 1'b0;
        end
        check({name, "_stall_cycles"}, stall_cyc, exp_stall);
        check({name, "_breq_cycles"}, breq_cyc, exp_breq);
        check({name, "_pulse_end"}, {30'd0, ld_vld, err}, 32'd0);
        check({name, "_ld_hold"}, ld_data, exp_ld);
    endtask

    initial begin
        rst_n = 1'b0; mem_req = 1'b1; mem_rw = 1'b0; funct3 = 3'b010; addr = 32'd0;
        wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #3;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_pulses", {30'd0, ld_vld, err}, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_bus_fields", {bus_we, bus_be, 27'd0} | bus_addr | bus_wdata, 32'd0);
        @(negedge clk); mem_req = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;

        //      name   rw    f3      addr          wdata         rdata     waits never  baddr          be       bwdata        vld   err   ld            stall breq
        run_op("LB",   1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 1'b0, 32'h0000_1000, 4'b1000, 32'd0,        1'b1, 1'b0, 32'hFFFF_FF80, 2, 1);
        run_op("LHU",  1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 3, 1'b0, 32'h0000_2000, 4'b1100, 32'd0,        1'b1, 1'b0, 32'h0000_BEEF, 5, 4);
        run_op("SB",   1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'd0, 0, 1'b0, 32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0000_BEEF, 2, 1);
        run_op("LH",   1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_0000, 1, 1'b0, 32'h0000_2000, 4'b1100, 32'd0,        1'b1, 1'b0, 32'hFFFF_8001, 3, 2);
        run_op("LBU",  1'b0, 3'b100, 32'h0000_0005, 32'd0, 32'h0000_F000, 0, 1'b0, 32'h0000_0004, 4'b0010, 32'd0,        1'b1, 1'b0, 32'h0000_00F0, 2, 1);
        run_op("SH",   1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 32'd0, 0, 1'b0, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0000_00F0, 2, 1);
        run_op("LWmis",1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0,         0, 1'b0, 32'd0,         4'b0000, 32'd0,        1'b0, 1'b1, 32'h0000_0000, 1, 0);
        run_op("LW",   1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'h1234_5678, 1, 1'b0, 32'h0000_0100, 4'b1111, 32'd0,        1'b1, 1'b0, 32'h1234_5678, 3, 2);
        run_op("LF3",  1'b0, 3'b011, 32'h0000_0000, 32'd0, 32'd0,         0, 1'b0, 32'd0,         4'b0000, 32'd0,        1'b0, 1'b1, 32'h0000_0000, 1, 0);
        run_op("SW",   1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'd0, 0, 1'b0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000, 2, 1);
        run_op("LWok", 1'b0, 3'b010, 32'h0000_0080, 32'd0, 32'h0BAD_F00D, 0, 1'b0, 32'h0000_0080, 4'b1111, 32'd0,        1'b1, 1'b0, 32'h0BAD_F00D, 2, 1);
        run_op("LWto", 1'b0, 3'b010, 32'h0000_0044, 32'd0, 32'd0,         0, 1'b1, 32'h0000_0044, 4'b1111, 32'd0,        1'b0, 1'b1, 32'h0000_0000, 5, 4);
        run_op("LWre", 1'b0, 3'b010, 32'h0000_0048, 32'd0, 32'h7777_8888, 0, 1'b0, 32'h0000_0048, 4'b1111, 32'd0,        1'b1, 1'b0, 32'h7777_8888, 2, 1);

        // Reset asserted while the bus request is outstanding.
        mem_req = 1'b1; mem_rw = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300; bus_ack = 1'b0;
        @(negedge clk); #1;
        check("mid_pre_bus_req", {31'd0, bus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_ld_data", ld_data, 32'd0);
        check("mid_rst_pulses", {30'd0, ld_vld, err}, 32'd0);
        @(negedge clk); mem_req = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
        run_op("LWpost", 1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 0, 1'b0, 32'h0000_0200, 4'b1111, 32'd0, 1'b1, 1'b0, 32'hCAFE_F00D, 2, 1);

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer between the single-cycle core's execute stage and a handshaked data-memory bus. On a decoded LOAD/STORE it stalls the PC, issues one aligned word access with byte enables, waits for acknowledge or timeout, then returns sign/zero-extended load data for the write-back mux (LD_DATA path). It also flags misaligned or illegal accesses.

## Interface
- TIMEOUT, 255: maximum cycles spent in ACCESS without `bus_ack` before abort (1..65535)
- CNT_W, $clog2(TIMEOUT+1): timeout counter width (derived, do not override)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_req  in  1  current instruction is LOAD or STORE; held stable by core while `stall`=1
- mem_rw  in  1  0=READ (load), 1=WRITE (store); mem_op encoding
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/pipeline this cycle
- ld_data  out  32  extended load result, valid when `ld_vld`
- ld_vld  out  1  one-cycle load-complete pulse
- err  out  1  one-cycle pulse: misalign, illegal funct3, or timeout
- bus_req  out  1  memory request
- bus_we  out  1  1=write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  memory completes request in this cycle
- bus_rdata  in  32  read word, valid with `bus_ack`

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if `mem_req`=1 → capture we/addr/be/wdata/funct3/addr[1:0]; legal → ACCESS; misaligned (H with addr[0]=1, W with addr[1:0]≠0) or illegal funct3 → DONE with error flag, no bus access.
- ACCESS: `bus_req`=1 with registered bus fields held constant. `bus_ack`=1 → DONE (load: capture extended data). Counter reaches TIMEOUT with no ack → DONE with error flag, `ld_data`=0.
- DONE: `stall`=0, `ld_vld`=1 only for successful load, `err`=1 if flagged; always → IDLE.
- `stall` = `mem_req` & (state≠DONE), combinational. IDLE-with-request stalls in the same cycle.
- Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111.
- Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
- Load extract: byte/half = bus_rdata >> (8·addr[1:0]); B/H sign-extend, BU/HU zero-extend, W unchanged.
- `bus_ack` outside ACCESS is ignored. `mem_req` dropping during ACCESS is ignored; transaction completes.
- Stores never assert `ld_vld`; failed loads assert `err` with `ld_data`=0.

## Timing
- Reset (async, any state): state IDLE, counter 0, all outputs 0. `bus_req` drops immediately, even mid-ACCESS.
- Best case: request seen in cycle T (IDLE), `bus_req` T+1, ack T+1, DONE T+2. `stall` is high T..T+1 and low at T+2, so 3 cycles per access.
- Each wait cycle in ACCESS adds one cycle.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles, then DONE with `err`=1.
- Error path: T IDLE, T+1 DONE with `err`=1. `stall` high only in T.
- Back-to-back: a new `mem_req` in the cycle after DONE starts a new access from IDLE. There is no dead cycle beyond IDLE.
- `ld_data` is registered and holds its value until the next completed load or reset.

## Test plan
- LB, addr=0x1003, bus_rdata=0x80FF_0000, ack on first ACCESS cycle → bus_addr=0x1000, be=1000, `ld_data`=0xFFFF_FF80, `ld_vld` at T+2, `stall` high 2 cycles.
- LHU, addr=0x2002, rdata=0xBEEF_1234, ack after 3 wait cycles → `ld_data`=0x0000_BEEF, `stall` high 5 cycles.
- SB, addr=0x11, wdata=0x0000_00A5 → bus_we=1, be=0010, bus_wdata=0xA5A5_A5A5, no `ld_vld`, no `err`.
- LW, addr=0x6 → no `bus_req`, `err` pulse at T+1, `ld_data`=0. Also funct3=011 → same behavior.
- TIMEOUT=4, never ack → `bus_req` high 4 cycles, then `err`=1, `ld_vld`=0, FSM back to IDLE.
- Assert `rst_n`=0 mid-ACCESS → `bus_req`, `stall`, and outputs 0 asynchronously. After release, a new LW completes normally.
